pipeline_hazard_ctrl: RTL and testbench

//  Central freeze/flush sequencer for the 5-stage pipeline. Drives PC/IF-ID freeze, IF-ID flush and ID-EX bubble

---
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencer for the 5-stage pipeline: data hazards, EX-resolved branches,
// MEM-stage wait with watchdog, and saturating stall/flush counters.
//
// state    | meaning
// RUN      | normal flow; hazards and branches handled combinationally
// MEM_WAIT | memory access outstanding; whole pipeline held
// HALT     | watchdog expired; pipeline frozen until reset
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_freeze,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              back_freeze,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              set_timeout;
  logic              flush_evt;
  logic              run_rules;
  logic              ex_match, mem_match, hazard;

  assign ex_match  = ex_wb_en & ((id_use_src1 & (id_src1 == ex_dest)) |
                                 (id_two_src  & (id_src2 == ex_dest)));
  assign mem_match = mem_wb_en & ((id_use_src1 & (id_src1 == mem_dest)) |
                                  (id_two_src  & (id_src2 == mem_dest)));
  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard    = forward_en ? (ex_mem_r_en & ex_match) : (ex_match | mem_match);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_timeout  = 1'b0;
    flush_evt    = 1'b0;
    run_rules    = 1'b0;
    pc_freeze    = 1'b0;
    back_freeze  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          pc_freeze    = 1'b1;
          back_freeze  = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_freeze    = 1'b1;
          back_freeze  = 1'b1;
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state_nxt   = HALT;
            set_timeout = 1'b1;
          end
        end else begin
          run_rules    = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      HALT: begin
        pc_freeze   = 1'b1;
        back_freeze = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    // A taken branch squashes the younger instruction, so any hazard on it is moot.
    if (run_rules) begin
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (hazard) begin
        pc_freeze   = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_freeze   = 1'b0;
      back_freeze = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_evt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_timeout)
        mem_timeout <= 1'b1;
      if (pc_freeze && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them. Narrow counters expose saturation.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW  = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 4;
  localparam int EXP_W   = 5 + 2 * CNT_W;

  logic clk, rst;
  logic forward_en, id_use_src1, id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en;
  logic branch_taken, mem_req, mem_ready;
  logic [REG_AW-1:0] id_src1, id_src2, ex_dest, mem_dest;
  logic pc_freeze, if_id_flush, id_ex_flush, back_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string            name;
    logic [EXP_W-1:0] val;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             cur;
  logic [EXP_W-1:0] act;
  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .back_freeze(back_freeze), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = {pc_freeze, if_id_flush, id_ex_flush, back_freeze, mem_timeout, stall_cnt, flush_cnt};
      checks++;
      if (act !== cur.val) begin
        failures++;
        $display("FAIL %s: actual {pc,ifl,idf,bf,to,stall,flush}=%b required=%b",
                 cur.name, act, cur.val);
      end
    end
  end

  task automatic clr_in();
    forward_en = 0; id_use_src1 = 0; id_two_src = 0; ex_wb_en = 0; ex_mem_r_en = 0;
    mem_wb_en = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    id_src1 = '0; id_src2 = '0; ex_dest = '0; mem_dest = '0;
  endtask

  task automatic hz();
    id_src1 = 4'd3; id_use_src1 = 1; ex_dest = 4'd3; ex_wb_en = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input bit pc, input bit ifl, input bit idf,
                            input bit bf, input bit to, input int s, input int f);
    exp_t e;
    e.name = nm;
    e.val  = {pc, ifl, idf, bf, to, CNT_W'(s), CNT_W'(f)};
    sb_q.push_back(e);
  endtask

  initial begin
    int s;
    rst = 1; clr_in();
    tick(); expect_out("reset", 0, 1, 1, 0, 0, 0, 0);
    tick(); rst = 0; expect_out("idle", 0, 0, 0, 0, 0, 0, 0);

    tick(); clr_in(); hz(); expect_out("ex_src1_hazard", 1, 0, 1, 0, 0, 0, 0);
    tick(); clr_in(); id_src1 = 3; id_use_src1 = 1; mem_dest = 3; mem_wb_en = 1;
    expect_out("mem_src1_hazard", 1, 0, 1, 0, 0, 1, 0);
    tick(); clr_in(); id_src1 = 3; id_two_src = 1; id_src2 = 5; ex_dest = 5; ex_wb_en = 1;
    expect_out("ex_src2_hazard", 1, 0, 1, 0, 0, 2, 0);
    tick(); clr_in(); id_src1 = 3; ex_dest = 3; ex_wb_en = 1;
    expect_out("src1_unused", 0, 0, 0, 0, 0, 3, 0);
    tick(); clr_in(); id_src1 = 3; id_use_src1 = 1; ex_dest = 3;
    expect_out("no_writeback", 0, 0, 0, 0, 0, 3, 0);
    tick(); clr_in(); hz(); ex_dest = 4; expect_out("diff_reg", 0, 0, 0, 0, 0, 3, 0);

    tick(); clr_in(); hz(); forward_en = 1; expect_out("fwd_alu", 0, 0, 0, 0, 0, 3, 0);
    tick(); clr_in(); hz(); forward_en = 1; ex_mem_r_en = 1;
    expect_out("fwd_load_use", 1, 0, 1, 0, 0, 3, 0);
    tick(); clr_in(); forward_en = 1; id_src1 = 3; id_use_src1 = 1; mem_dest = 3; mem_wb_en = 1;
    ex_dest = 7; ex_wb_en = 1; ex_mem_r_en = 1;
    expect_out("fwd_mem_ignored", 0, 0, 0, 0, 0, 4, 0);

    tick(); clr_in(); hz(); branch_taken = 1; expect_out("branch_over_hazard", 0, 1, 1, 0, 0, 4, 0);
    tick(); clr_in(); expect_out("after_branch", 0, 0, 0, 0, 0, 4, 1);

    tick(); clr_in(); rst = 1; expect_out("reset2", 0, 1, 1, 0, 0, 0, 0);
    tick(); rst = 0; expect_out("idle2", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      tick(); clr_in(); mem_req = 1; expect_out("mem_wait", 1, 0, 0, 1, 0, i, 0);
    end
    tick(); clr_in(); mem_req = 1; mem_ready = 1; expect_out("mem_release", 0, 0, 0, 0, 0, 3, 0);
    tick(); clr_in(); expect_out("run_after_wait", 0, 0, 0, 0, 0, 3, 0);
    tick(); clr_in(); mem_req = 1; mem_ready = 1; expect_out("req_ready_same", 0, 0, 0, 0, 0, 3, 0);
    tick(); clr_in(); expect_out("after_same", 0, 0, 0, 0, 0, 3, 0);

    tick(); clr_in(); mem_req = 1; branch_taken = 1; expect_out("br_vs_memreq", 1, 0, 0, 1, 0, 3, 0);
    tick(); clr_in(); mem_req = 1; branch_taken = 1; expect_out("br_in_wait", 1, 0, 0, 1, 0, 4, 0);
    tick(); clr_in(); mem_req = 1; mem_ready = 1; branch_taken = 1;
    expect_out("br_at_release", 0, 1, 1, 0, 0, 5, 0);
    tick(); clr_in(); expect_out("after_br_release", 0, 0, 0, 0, 0, 5, 1);
    tick(); clr_in(); mem_req = 1; expect_out("wait_b", 1, 0, 0, 1, 0, 5, 1);
    tick(); clr_in(); mem_req = 1; mem_ready = 1; hz();
    expect_out("hazard_at_release", 1, 0, 1, 0, 0, 6, 1);
    tick(); clr_in(); expect_out("after_hz_release", 0, 0, 0, 0, 0, 7, 1);

    for (int k = 1; k <= TIMEOUT; k++) begin
      s = (7 + k - 1 > 15) ? 15 : 7 + k - 1;
      tick(); clr_in(); mem_req = 1; expect_out("watchdog_wait", 1, 0, 0, 1, 0, s, 1);
    end
    tick(); clr_in(); mem_req = 1; mem_ready = 1; branch_taken = 1;
    expect_out("halt_ignores_ready", 1, 0, 0, 1, 1, 15, 1);
    tick(); clr_in(); expect_out("halt_sticky", 1, 0, 0, 1, 1, 15, 1);
    tick(); clr_in(); rst = 1; expect_out("halt_reset", 0, 1, 1, 0, 0, 0, 0);
    tick(); rst = 0; expect_out("run_after_halt", 0, 0, 0, 0, 0, 0, 0);

    tick(); clr_in(); mem_req = 1; expect_out("wait_c", 1, 0, 0, 1, 0, 0, 0);
    tick(); clr_in(); mem_req = 1; rst = 1; expect_out("reset_mid_wait", 0, 1, 1, 0, 0, 0, 0);
    tick(); clr_in(); rst = 0; expect_out("run_after_wait_reset", 0, 0, 0, 0, 0, 0, 0);

    tick(); clr_in();
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
